// File: rtl/pll_ctrl_pkg.sv
// Shared types, defaults and sizing helper for the rPLL lock supervisor.
package pll_ctrl_pkg;

    localparam int unsigned SEL_W = 6;

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        LOCKED     = 3'd3,
        FAULT      = 3'd4
    } pll_state_e;

    typedef struct packed {
        logic [SEL_W-1:0] idsel;
        logic [SEL_W-1:0] fbdsel;
        logic [SEL_W-1:0] odsel;
    } pll_sel_t;

    localparam logic [SEL_W-1:0] DEFAULT_IDSEL  = 6'd0;
    localparam logic [SEL_W-1:0] DEFAULT_FBDSEL = 6'd0;
    localparam logic [SEL_W-1:0] DEFAULT_ODSEL  = 6'd0;

    // Bits needed to count 0..value-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned value);
        return (value > 1) ? unsigned'($clog2(value)) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// rPLL supervisor: reset sequencing, lock qualification, retry/fault handling
// and divider reconfiguration, all in the reference clock domain.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned      RST_CYCLES   = 16,
    parameter int unsigned      LOCK_STABLE  = 1024,
    parameter int unsigned      LOCK_TIMEOUT = 65536,
    parameter int unsigned      MAX_RETRY    = 3,
    parameter logic [SEL_W-1:0] DEF_IDSEL    = DEFAULT_IDSEL,
    parameter logic [SEL_W-1:0] DEF_FBDSEL   = DEFAULT_FBDSEL,
    parameter logic [SEL_W-1:0] DEF_ODSEL    = DEFAULT_ODSEL
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             cfg_req,
    input  logic [SEL_W-1:0] cfg_idsel,
    input  logic [SEL_W-1:0] cfg_fbdsel,
    input  logic [SEL_W-1:0] cfg_odsel,
    output logic             cfg_ack,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [SEL_W-1:0] pll_idsel,
    output logic [SEL_W-1:0] pll_fbdsel,
    output logic [SEL_W-1:0] pll_odsel,
    output logic             sys_rst_n,
    output logic             locked,
    output logic             fault,
    output logic [2:0]       state
);

    localparam int unsigned CNT_MAX_A = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
    localparam int unsigned CNT_W     = cnt_width(CNT_MAX);
    localparam int unsigned RETRY_W   = cnt_width(MAX_RETRY + 1);
    localparam pll_sel_t    DEF_SEL   = '{idsel: DEF_IDSEL, fbdsel: DEF_FBDSEL, odsel: DEF_ODSEL};

    pll_state_e         state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [RETRY_W-1:0] retry_q, retry_nxt, retry_inc;
    logic               accept;
    logic               lock_s;
    logic               lock_gated;
    pll_sel_t           sel_q;
    logic               pll_reset_nxt, sys_rst_n_nxt, locked_nxt, fault_nxt;

    // LOCK is meaningless while the PLL is held in reset; gating it here also
    // flushes any stale lock_s before a fresh WAIT_LOCK window starts.
    assign lock_gated = pll_lock & ~pll_reset;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (lock_gated),
        .q     (lock_s)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_HOLD;
            cnt_q   <= '0;
            retry_q <= '0;
            sel_q   <= DEF_SEL;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            retry_q <= retry_nxt;
            if (accept) begin
                sel_q <= '{idsel: cfg_idsel, fbdsel: cfg_fbdsel, odsel: cfg_odsel};
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        retry_nxt = retry_q;
        accept    = 1'b0;
        retry_inc = retry_q + RETRY_W'(1);
        case (state_q)
            RESET_HOLD: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    // The sample that ends the wait is the first stable cycle.
                    state_nxt = STABLE;
                    cnt_nxt   = CNT_W'(1);
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_nxt = retry_inc;
                    cnt_nxt   = '0;
                    state_nxt = (retry_inc == RETRY_W'(MAX_RETRY)) ? FAULT : RESET_HOLD;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                    state_nxt = LOCKED;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (cfg_req) begin
                    accept = 1'b1;
                end else if (!lock_s) begin
                    state_nxt = RESET_HOLD;
                    cnt_nxt   = '0;
                end
            end
            FAULT: begin
                if (cfg_req) begin
                    accept = 1'b1;
                end
            end
            default: begin
                state_nxt = RESET_HOLD;
                cnt_nxt   = '0;
            end
        endcase
        if (accept) begin
            state_nxt = RESET_HOLD;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_comb begin
        pll_reset_nxt = 1'b1;
        sys_rst_n_nxt = 1'b0;
        locked_nxt    = 1'b0;
        fault_nxt     = 1'b0;
        case (state_nxt)
            WAIT_LOCK, STABLE: pll_reset_nxt = 1'b0;
            LOCKED: begin
                pll_reset_nxt = 1'b0;
                sys_rst_n_nxt = 1'b1;
                locked_nxt    = 1'b1;
            end
            FAULT:   fault_nxt = 1'b1;
            default: pll_reset_nxt = 1'b1;
        endcase
    end

    // Selects trail sel_q by one cycle so they only move while pll_reset is high.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            pll_reset  <= 1'b1;
            sys_rst_n  <= 1'b0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            cfg_ack    <= 1'b0;
            pll_idsel  <= DEF_IDSEL;
            pll_fbdsel <= DEF_FBDSEL;
            pll_odsel  <= DEF_ODSEL;
        end else begin
            pll_reset  <= pll_reset_nxt;
            sys_rst_n  <= sys_rst_n_nxt;
            locked     <= locked_nxt;
            fault      <= fault_nxt;
            cfg_ack    <= accept;
            pll_idsel  <= sel_q.idsel;
            pll_fbdsel <= sel_q.fbdsel;
            pll_odsel  <= sel_q.odsel;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scenario bench for pll_lock_ctrl with small timing parameters and a
// timeline model of when lock, timeout and reset pulses must occur.
module tb_pll_lock_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 32;
    localparam int MAX_RETRY    = 2;
    localparam int SYNC_LAT     = 2;

    logic       clkin = 1'b0;
    logic       rst_n;
    logic       cfg_req;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic       cfg_ack;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       sys_rst_n, locked, fault;
    logic [2:0] state;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .cfg_req   (cfg_req),
        .cfg_idsel (cfg_idsel),
        .cfg_fbdsel(cfg_fbdsel),
        .cfg_odsel (cfg_odsel),
        .cfg_ack   (cfg_ack),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_idsel (pll_idsel),
        .pll_fbdsel(pll_fbdsel),
        .pll_odsel (pll_odsel),
        .sys_rst_n (sys_rst_n),
        .locked    (locked),
        .fault     (fault),
        .state     (state)
    );

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    // Edge (relative to the pll_reset fall) at which locked must rise when raw
    // lock goes high d cycles into a WAIT window: lock is first seen SYNC_LAT+1
    // edges later; if that misses the timeout, a full new reset/wait round follows.
    function automatic int exp_lock_delay(input int d);
        int seen;
        seen = d + SYNC_LAT + 1;
        if (seen <= LOCK_TIMEOUT) return seen + LOCK_STABLE - 1;
        return LOCK_TIMEOUT + RST_CYCLES + SYNC_LAT + LOCK_STABLE;
    endfunction

    function automatic logic sig_val(input int which);
        case (which)
            0:       return pll_reset;
            1:       return locked;
            2:       return fault;
            default: return cfg_ack;
        endcase
    endfunction

    // Returns the cycle index at which the signal first shows val, or -1.
    task automatic wait_sig(input int which, input logic val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clkin);
            if (sig_val(which) === val) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic apply_reset(input logic lk, output int rel);
        @(negedge clkin);
        rst_n = 1'b0; cfg_req = 1'b0;
        cfg_idsel = '0; cfg_fbdsel = '0; cfg_odsel = '0;
        pll_lock = lk;
        repeat (3) @(negedge clkin);
        rst_n = 1'b1;
        rel = cyc;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cfg_req = 1'b0; pll_lock = 1'b1;
        cfg_idsel = 6'd7; cfg_fbdsel = 6'd9; cfg_odsel = 6'd11;
        repeat (3) @(negedge clkin);
        n_tests++; if (pll_reset !== 1'b1) begin n_fail++; $display("FAIL reset_pll_reset got %b want 1", pll_reset); end
        n_tests++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst_n got %b want 0", sys_rst_n); end
        n_tests++; if (locked !== 1'b0 || fault !== 1'b0 || cfg_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got locked=%b fault=%b ack=%b want 0", locked, fault, cfg_ack); end
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_tests++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== 18'd0) begin
            n_fail++; $display("FAIL reset_sels got %0d/%0d/%0d want 0/0/0", pll_idsel, pll_fbdsel, pll_odsel); end
    endtask

    task automatic test_powerup_tied1;
        int rel, f, l;
        apply_reset(1'b1, rel);
        wait_sig(0, 1'b0, 20, f);
        n_tests++; if (f - rel !== RST_CYCLES) begin n_fail++; $display("FAIL pwr_reset_width got %0d want %0d", f - rel, RST_CYCLES); end
        wait_sig(1, 1'b1, 60, l);
        n_tests++; if (l - f !== SYNC_LAT + LOCK_STABLE) begin
            n_fail++; $display("FAIL pwr_lock_delay got %0d want %0d", l - f, SYNC_LAT + LOCK_STABLE); end
        n_tests++; if (l - rel !== RST_CYCLES + SYNC_LAT + LOCK_STABLE) begin
            n_fail++; $display("FAIL pwr_total got %0d want %0d", l - rel, RST_CYCLES + SYNC_LAT + LOCK_STABLE); end
        n_tests++; if (sys_rst_n !== 1'b1 || state !== 3'd3) begin
            n_fail++; $display("FAIL pwr_locked got sys_rst_n=%b state=%0d want 1/3", sys_rst_n, state); end
    endtask

    task automatic test_glitch;
        int rel, f, g, l, j;
        apply_reset(1'b1, rel);
        wait_sig(0, 1'b0, 20, f);
        j = int'($urandom_range(6, 1));
        repeat (j) @(negedge clkin);
        g = cyc;
        pll_lock = 1'b0;
        @(negedge clkin);
        pll_lock = 1'b1;
        repeat (2) @(negedge clkin);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL glitch_state got %0d want 1 (j=%0d)", state, j); end
        n_tests++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL glitch_sys_rst_n got %b want 0", sys_rst_n); end
        wait_sig(1, 1'b1, 40, l);
        n_tests++; if (l - g !== SYNC_LAT + 1 + LOCK_STABLE) begin
            n_fail++; $display("FAIL glitch_relock got %0d want %0d", l - g, SYNC_LAT + 1 + LOCK_STABLE); end
    endtask

    task automatic test_timeout_fault;
        int rel, f1, r1, f2, t;
        apply_reset(1'b0, rel);
        wait_sig(0, 1'b0, 20, f1);
        n_tests++; if (f1 - rel !== RST_CYCLES) begin n_fail++; $display("FAIL to_reset1 got %0d want %0d", f1 - rel, RST_CYCLES); end
        wait_sig(0, 1'b1, 64, r1);
        n_tests++; if (r1 - f1 !== LOCK_TIMEOUT) begin n_fail++; $display("FAIL to_wait1 got %0d want %0d", r1 - f1, LOCK_TIMEOUT); end
        n_tests++; if (fault !== 1'b0 || state !== 3'd0) begin
            n_fail++; $display("FAIL to_retry1 got fault=%b state=%0d want 0/0", fault, state); end
        wait_sig(0, 1'b0, 20, f2);
        n_tests++; if (f2 - r1 !== RST_CYCLES) begin n_fail++; $display("FAIL to_reset2 got %0d want %0d", f2 - r1, RST_CYCLES); end
        wait_sig(2, 1'b1, 64, t);
        n_tests++; if (t - f2 !== LOCK_TIMEOUT) begin n_fail++; $display("FAIL to_wait2 got %0d want %0d", t - f2, LOCK_TIMEOUT); end
        n_tests++; if (pll_reset !== 1'b1 || state !== 3'd4 || sys_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL to_fault got pll_reset=%b state=%0d sys_rst_n=%b want 1/4/0", pll_reset, state, sys_rst_n); end
    endtask

    task automatic test_cfg_fault;
        int a, k, f;
        repeat (5) @(negedge clkin);
        n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky got %b want 1", fault); end
        cfg_req = 1'b1; cfg_idsel = 6'd3; cfg_fbdsel = 6'd59; cfg_odsel = 6'd48;
        a = cyc;
        wait_sig(3, 1'b1, 5, k);
        n_tests++; if (k - a !== 1) begin n_fail++; $display("FAIL cfgf_ack_time got %0d want 1", k - a); end
        n_tests++; if (fault !== 1'b0 || pll_reset !== 1'b1 || state !== 3'd0) begin
            n_fail++; $display("FAIL cfgf_accept got fault=%b pll_reset=%b state=%0d want 0/1/0", fault, pll_reset, state); end
        n_tests++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== 18'd0) begin
            n_fail++; $display("FAIL cfgf_sel_early got %0d/%0d/%0d want 0/0/0", pll_idsel, pll_fbdsel, pll_odsel); end
        cfg_req = 1'b0;
        @(negedge clkin);
        n_tests++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL cfgf_ack_width got %b want 0", cfg_ack); end
        n_tests++; if (pll_idsel !== 6'd3 || pll_fbdsel !== 6'd59 || pll_odsel !== 6'd48 || pll_reset !== 1'b1) begin
            n_fail++; $display("FAIL cfgf_sel got %0d/%0d/%0d rst=%b want 3/59/48 rst=1", pll_idsel, pll_fbdsel, pll_odsel, pll_reset); end
        wait_sig(0, 1'b0, 20, f);
        n_tests++; if (f - k !== RST_CYCLES) begin n_fail++; $display("FAIL cfgf_reset_width got %0d want %0d", f - k, RST_CYCLES); end
    endtask

    task automatic test_lock_loss;
        int rel, l, d, x, f, r, f2, l2;
        apply_reset(1'b1, rel);
        wait_sig(1, 1'b1, 60, l);
        repeat (2) @(negedge clkin);
        d = cyc;
        pll_lock = 1'b0;
        wait_sig(1, 1'b0, 6, x);
        n_tests++; if (x < 0 || x - d > SYNC_LAT + 1 || sys_rst_n !== 1'b0 || pll_reset !== 1'b1) begin
            n_fail++; $display("FAIL loss_drop got delay=%0d sys_rst_n=%b pll_reset=%b want <=3/0/1", x - d, sys_rst_n, pll_reset); end
        wait_sig(0, 1'b0, 20, f);
        n_tests++; if (f - x !== RST_CYCLES) begin n_fail++; $display("FAIL loss_reset_width got %0d want %0d", f - x, RST_CYCLES); end
        wait_sig(0, 1'b1, 64, r);
        n_tests++; if (r - f !== LOCK_TIMEOUT || fault !== 1'b0 || state !== 3'd0) begin
            n_fail++; $display("FAIL loss_retry got wait=%0d fault=%b state=%0d want %0d/0/0", r - f, fault, state, LOCK_TIMEOUT); end
        pll_lock = 1'b1;
        wait_sig(0, 1'b0, 20, f2);
        wait_sig(1, 1'b1, 60, l2);
        n_tests++; if (l2 - f2 !== exp_lock_delay(0)) begin
            n_fail++; $display("FAIL loss_relock got %0d want %0d", l2 - f2, exp_lock_delay(0)); end
    endtask

    task automatic test_cfg_pending;
        int rel, f, l, early;
        logic [17:0] req;
        apply_reset(1'b0, rel);
        wait_sig(0, 1'b0, 20, f);
        repeat (2) @(negedge clkin);
        req = {6'($urandom_range(63, 1)), 6'($urandom_range(63, 1)), 6'($urandom_range(63, 1))};
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = req;
        cfg_req = 1'b1;
        pll_lock = 1'b1;
        l = -1; early = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clkin);
            if (locked === 1'b1) begin l = cyc; break; end
            if (cfg_ack === 1'b1) early++;
        end
        n_tests++; if (early !== 0 || l - f !== exp_lock_delay(2)) begin
            n_fail++; $display("FAIL pend_lock got early_acks=%0d lock=%0d want 0/%0d", early, l - f, exp_lock_delay(2)); end
        n_tests++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL pend_ack_early got %b want 0", cfg_ack); end
        @(negedge clkin);
        n_tests++; if (cfg_ack !== 1'b1 || locked !== 1'b0 || sys_rst_n !== 1'b0 || pll_reset !== 1'b1) begin
            n_fail++; $display("FAIL pend_accept got ack=%b locked=%b sys_rst_n=%b rst=%b want 1/0/0/1", cfg_ack, locked, sys_rst_n, pll_reset); end
        cfg_req = 1'b0;
        @(negedge clkin);
        n_tests++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== req || cfg_ack !== 1'b0) begin
            n_fail++; $display("FAIL pend_sel got %h ack=%b want %h ack=0", {pll_idsel, pll_fbdsel, pll_odsel}, cfg_ack, req); end
    endtask

    task automatic test_same_cycle;
        int l, d;
        logic [17:0] req;
        wait_sig(1, 1'b1, 60, l);
        repeat (2) @(negedge clkin);
        d = cyc;
        pll_lock = 1'b0;
        repeat (2) @(negedge clkin);
        req = {6'($urandom_range(63, 1)), 6'($urandom_range(63, 1)), 6'($urandom_range(63, 1))};
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = req;
        cfg_req = 1'b1;
        @(negedge clkin);
        n_tests++; if (cfg_ack !== 1'b1 || state !== 3'd0 || cyc - d !== SYNC_LAT + 1) begin
            n_fail++; $display("FAIL same_ack got ack=%b state=%0d want 1/0", cfg_ack, state); end
        cfg_req = 1'b0;
        @(negedge clkin);
        n_tests++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== req || pll_reset !== 1'b1) begin
            n_fail++; $display("FAIL same_sel got %h rst=%b want %h rst=1", {pll_idsel, pll_fbdsel, pll_odsel}, pll_reset, req); end
    endtask

    task automatic test_rst_mid;
        int rel, f;
        pll_lock = 1'b1;
        repeat (7) @(negedge clkin);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (pll_reset !== 1'b1 || state !== 3'd0 || sys_rst_n !== 1'b0 || {pll_idsel, pll_fbdsel, pll_odsel} !== 18'd0) begin
            n_fail++; $display("FAIL mid_rst got rst=%b state=%0d sys=%b sels=%h want 1/0/0/0", pll_reset, state, sys_rst_n, {pll_idsel, pll_fbdsel, pll_odsel}); end
        @(negedge clkin);
        rst_n = 1'b1;
        rel = cyc;
        wait_sig(0, 1'b0, 20, f);
        n_tests++; if (f - rel !== RST_CYCLES || {pll_idsel, pll_fbdsel, pll_odsel} !== 18'd0) begin
            n_fail++; $display("FAIL mid_release got width=%0d sels=%h want %0d/0", f - rel, {pll_idsel, pll_fbdsel, pll_odsel}, RST_CYCLES); end
    endtask

    task automatic test_random_lock;
        int rel, f, l, d;
        for (int it = 0; it < 6; it++) begin
            d = (it == 0) ? LOCK_TIMEOUT - SYNC_LAT - 1 :
                (it == 1) ? LOCK_TIMEOUT - SYNC_LAT : int'($urandom_range(35, 0));
            apply_reset(1'b0, rel);
            wait_sig(0, 1'b0, 20, f);
            repeat (d) @(negedge clkin);
            pll_lock = 1'b1;
            wait_sig(1, 1'b1, 90, l);
            n_tests++; if (l - f !== exp_lock_delay(d) || fault !== 1'b0) begin
                n_fail++; $display("FAIL rand_lock d=%0d got %0d fault=%b want %0d/0", d, l - f, fault, exp_lock_delay(d)); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_powerup_tied1();
        test_glitch();
        test_timeout_fault();
        test_cfg_fault();
        test_lock_loss();
        test_cfg_pending();
        test_same_cycle();
        test_rst_mid();
        test_random_lock();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
